// File: rtl/spi_slave_param.sv
// Parametrised SPI slave on the system clock: synchronised sck/ss/mosi, CPOL/CPHA modes,
// selectable bit order, one-entry TX buffer with valid/ready, back-to-back words per ss frame.
module spi_slave_param #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             underrun,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic          IDLE     = (CPOL != 0);
  localparam bit            PHASE1   = (CPHA != 0);
  localparam bit            MSBF     = (MSB_FIRST != 0);

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, ss_s, mosi_s;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d;
  logic             tx_ready_q, tx_ready_d;
  logic             miso_q, miso_d;

  logic             lead, trail, ss_fall, sample_edge, shift_edge, load, hs;
  logic [WIDTH-1:0] rx_word;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= {SYNC_STAGES{IDLE}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= IDLE;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  always_comb begin
    lead        = !ss_s && (sck_prev_q == IDLE) && (sck_s != IDLE);
    trail       = !ss_s && (sck_prev_q != IDLE) && (sck_s == IDLE);
    ss_fall     = ss_prev_q && !ss_s;
    sample_edge = PHASE1 ? trail : lead;
    shift_edge  = PHASE1 ? lead : trail;
    // CPHA=0 reloads on the trailing edge after a completed word (counter back at 0)
    load        = PHASE1 ? (lead && (cnt_q == '0))
                         : (ss_fall || (trail && (cnt_q == '0)));
    hs          = tx_valid && tx_ready_q;

    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    rx_word    = MSBF ? {rx_shift_q[WIDTH-2:0], mosi_s} : {mosi_s, rx_shift_q[WIDTH-1:1]};

    if (ss_s) begin
      cnt_d      = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
    end else begin
      if (sample_edge) begin
        rx_shift_d = rx_word;
        if (cnt_q == LAST_BIT) begin
          cnt_d      = '0;
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      if (load) begin
        if (buf_full_q) begin
          tx_shift_d = buf_q;
          buf_full_d = 1'b0;
        end else begin
          tx_shift_d = '0;
          underrun_d = 1'b1;
        end
      end else if (shift_edge) begin
        tx_shift_d = MSBF ? {tx_shift_q[WIDTH-2:0], 1'b0} : {1'b0, tx_shift_q[WIDTH-1:1]};
      end
    end

    // A handshake alongside an empty-buffer load refills for the next word only
    if (hs) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    tx_ready_d = !buf_full_d;
    miso_d     = ss_s ? 1'b0 : (MSBF ? tx_shift_d[WIDTH-1] : tx_shift_d[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      tx_ready_q <= 1'b1;
      miso_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      tx_ready_q <= tx_ready_d;
      miso_q     <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign underrun = underrun_q;
  assign busy     = !ss_s;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: four instances (mode 0 8-bit MSB-first, modes 1/2/3 12-bit LSB-first)
// driven by a bit-banged SPI master, a TX feeder and an rx_valid scoreboard.
module tb_spi_slave_param;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck[4], ss[4], mosi[4], tx_valid[4];
  logic [11:0] tx_bus;

  logic        miso0, miso1, miso2, miso3, txr0, txr1, txr2, txr3;
  logic        rxv0, rxv1, rxv2, rxv3, ur0, ur1, ur2, ur3, busy0, busy1, busy2, busy3;
  logic [7:0]  rxd0;
  logic [11:0] rxd1, rxd2, rxd3;
  logic        miso_a[4], ready_a[4], rxv_a[4], ur_a[4], busy_a[4];
  logic [11:0] rxd_a[4];

  int dw[4]   = '{8, 12, 12, 12};
  bit cpol[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  bit cpha[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  bit msbf[4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  spi_slave_param #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .sck(sck[0]), .ss(ss[0]), .mosi(mosi[0]), .miso(miso0),
    .tx_data(tx_bus[7:0]), .tx_valid(tx_valid[0]), .tx_ready(txr0), .rx_data(rxd0),
    .rx_valid(rxv0), .underrun(ur0), .busy(busy0));
  spi_slave_param #(.WIDTH(12), .CPOL(0), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .sck(sck[1]), .ss(ss[1]), .mosi(mosi[1]), .miso(miso1),
    .tx_data(tx_bus), .tx_valid(tx_valid[1]), .tx_ready(txr1), .rx_data(rxd1),
    .rx_valid(rxv1), .underrun(ur1), .busy(busy1));
  spi_slave_param #(.WIDTH(12), .CPOL(1), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .sck(sck[2]), .ss(ss[2]), .mosi(mosi[2]), .miso(miso2),
    .tx_data(tx_bus), .tx_valid(tx_valid[2]), .tx_ready(txr2), .rx_data(rxd2),
    .rx_valid(rxv2), .underrun(ur2), .busy(busy2));
  spi_slave_param #(.WIDTH(12), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .sck(sck[3]), .ss(ss[3]), .mosi(mosi[3]), .miso(miso3),
    .tx_data(tx_bus), .tx_valid(tx_valid[3]), .tx_ready(txr3), .rx_data(rxd3),
    .rx_valid(rxv3), .underrun(ur3), .busy(busy3));

  always_comb begin
    miso_a[0] = miso0; miso_a[1] = miso1; miso_a[2] = miso2; miso_a[3] = miso3;
    ready_a[0] = txr0; ready_a[1] = txr1; ready_a[2] = txr2; ready_a[3] = txr3;
    rxv_a[0] = rxv0; rxv_a[1] = rxv1; rxv_a[2] = rxv2; rxv_a[3] = rxv3;
    ur_a[0] = ur0; ur_a[1] = ur1; ur_a[2] = ur2; ur_a[3] = ur3;
    busy_a[0] = busy0; busy_a[1] = busy1; busy_a[2] = busy2; busy_a[3] = busy3;
    rxd_a[0] = {4'h0, rxd0}; rxd_a[1] = rxd1; rxd_a[2] = rxd2; rxd_a[3] = rxd3;
  end

  // Monitor: logs every rx_valid pulse and counts underrun pulses per instance
  int          log_d[256];
  logic [11:0] log_v[256];
  int          log_n, rxv_n[4], ur_n[4];

  initial begin
    log_n = 0;
    for (int i = 0; i < 4; i++) begin rxv_n[i] = 0; ur_n[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rxv_a[i] === 1'b1) begin
          rxv_n[i]++;
          if (log_n < 256) begin log_d[log_n] = i; log_v[log_n] = rxd_a[i]; log_n++; end
        end
        if (ur_a[i] === 1'b1) ur_n[i]++;
      end
    end
  end

  // Feeder: offers queued words on tx_valid/tx_data to instance cur whenever tx_ready is high
  logic [11:0] feed_mem[64];
  int          feed_wr, feed_rd, cur;
  bit          feed_on_busy;

  initial begin
    feed_rd = 0;
    tx_bus  = '0;
    for (int i = 0; i < 4; i++) tx_valid[i] = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid[cur]) begin
        tx_valid[cur] = 1'b0;
        feed_rd++;
      end else if (feed_rd < feed_wr && ready_a[cur] && (!feed_on_busy || busy_a[cur])) begin
        tx_bus        = feed_mem[feed_rd % 64];
        tx_valid[cur] = 1'b1;
      end
    end
  end

  typedef struct { int d; logic [11:0] v; } exp_t;
  typedef struct { int d; logic [11:0] pre; logic [11:0] send; } vec_t;

  exp_t        exp_q[$];
  int          sb_rd, checks, failures;
  logic [11:0] last_rx[4];
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic wait_h();
    repeat (H) @(negedge clk);
  endtask

  task automatic push_feed(input logic [11:0] w);
    feed_mem[feed_wr % 64] = w;
    feed_wr++;
  endtask

  task automatic wait_fed(input int target, input string name);
    int n;
    n = 0;
    while (feed_rd < target && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (feed_rd < target) begin
      failures++;
      $display("FAIL %s: words taken %0d required %0d", name, feed_rd, target);
    end
  endtask

  task automatic expect_rx(input int d, input logic [11:0] v);
    exp_t e;
    e.d = d; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    exp_t e;
    while (sb_rd < log_n) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_rx_unexpected: got dut %0d data %h required none", name, log_d[sb_rd], log_v[sb_rd]);
      end else begin
        e = exp_q.pop_front();
        if (log_d[sb_rd] != e.d || log_v[sb_rd] !== e.v) begin
          failures++;
          $display("FAIL %s_rx_word: got dut %0d data %h required dut %0d data %h",
                   name, log_d[sb_rd], log_v[sb_rd], e.d, e.v);
        end
      end
      sb_rd++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_rx_missing: got %0d words outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic ss_assert(input int d);
    ss[d] = 1'b0;
    wait_h();
  endtask

  task automatic ss_release(input int d);
    wait_h();
    ss[d] = 1'b1;
    repeat (3 * H) @(negedge clk);
  endtask

  task automatic xfer(input int d, input int nbits, input logic [11:0] mo, output logic [11:0] mi);
    int idx;
    mi = '0;
    for (int b = 0; b < nbits; b++) begin
      idx = msbf[d] ? dw[d] - 1 - b : b;
      if (!cpha[d]) begin
        mosi[d] = mo[idx];
        wait_h();
        sck[d]  = !cpol[d];
        mi[idx] = miso_a[d];
        wait_h();
        sck[d]  = cpol[d];
      end else begin
        sck[d]  = !cpol[d];
        mosi[d] = mo[idx];
        wait_h();
        sck[d]  = cpol[d];
        mi[idx] = miso_a[d];
        wait_h();
      end
    end
  endtask

  task automatic apply_vec(input vec_t v);
    logic [11:0] got;
    int          r0;
    cur = v.d;
    push_feed(v.pre);
    wait_fed(feed_wr, "preload");
    r0 = rxv_n[v.d];
    expect_rx(v.d, v.send);
    ss_assert(v.d);
    xfer(v.d, dw[v.d], v.send, got);
    ss_release(v.d);
    drain("vec");
    chk("miso_word", got, v.pre);
    chk("rx_data", rxd_a[v.d], v.send);
    chk("rx_valid_cnt", 12'(rxv_n[v.d] - r0), 12'd1);
    last_rx[v.d] = v.send;
  endtask

  initial begin
    logic [11:0] g0, g1, g2;
    int          r0, u0c;

    tbl[0] = '{0, 12'h000, 12'h0AA};
    tbl[1] = '{0, 12'h0AA, 12'h0FF};
    tbl[2] = '{0, 12'h0FF, 12'h000};
    tbl[3] = '{1, 12'h3F1, 12'hA5C};
    tbl[4] = '{2, 12'h3F1, 12'hA5C};
    tbl[5] = '{3, 12'h3F1, 12'hA5C};
    tbl[6] = '{1, 12'hA5C, 12'h3F1};
    tbl[7] = '{2, 12'h801, 12'h001};

    checks = 0; failures = 0; sb_rd = 0;
    feed_wr = 0; cur = 0; feed_on_busy = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sck[i] = cpol[i]; ss[i] = 1'b1; mosi[i] = 1'b0; last_rx[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_miso", 12'(miso_a[i]), 12'd0);
      chk("rst_tx_ready", 12'(ready_a[i]), 12'd1);
      chk("rst_rx_data", rxd_a[i], 12'h000);
      chk("rst_rx_valid", 12'(rxv_a[i]), 12'd0);
      chk("rst_underrun", 12'(ur_a[i]), 12'd0);
      chk("rst_busy", 12'(busy_a[i]), 12'd0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) apply_vec(tbl[i]);

    // Back-to-back words in one frame; a fourth word keeps the buffer full for the closing load
    cur = 0;
    push_feed(12'h011); push_feed(12'h022); push_feed(12'h033); push_feed(12'h044);
    wait_fed(feed_wr - 3, "b2b_preload");
    u0c = ur_n[0]; r0 = rxv_n[0];
    expect_rx(0, 12'h0AA); expect_rx(0, 12'h0BE); expect_rx(0, 12'h055);
    ss_assert(0);
    xfer(0, 8, 12'h0AA, g0);
    xfer(0, 8, 12'h0BE, g1);
    xfer(0, 8, 12'h055, g2);
    ss_release(0);
    drain("b2b");
    chk("b2b_word0", g0, 12'h011);
    chk("b2b_word1", g1, 12'h022);
    chk("b2b_word2", g2, 12'h033);
    chk("b2b_rx_valid_cnt", 12'(rxv_n[0] - r0), 12'd3);
    chk("b2b_underrun_cnt", 12'(ur_n[0] - u0c), 12'd0);
    wait_fed(feed_wr, "b2b_refill");
    last_rx[0] = 12'h055;

    // Empty buffer at ss fall with a handshake in the same clk as the load
    feed_on_busy = 1'b1;
    push_feed(12'h07E);
    u0c = ur_n[0]; r0 = rxv_n[0];
    expect_rx(0, 12'h0C3); expect_rx(0, 12'h018);
    ss_assert(0);
    xfer(0, 8, 12'h0C3, g0);
    xfer(0, 8, 12'h018, g1);
    ss_release(0);
    feed_on_busy = 1'b0;
    drain("ur");
    chk("ur_word0", g0, 12'h000);
    chk("ur_word1", g1, 12'h07E);
    chk("ur_underrun_cnt", 12'(ur_n[0] - u0c), 12'd2);
    chk("ur_rx_valid_cnt", 12'(rxv_n[0] - r0), 12'd2);
    wait_fed(feed_wr, "ur_fed");
    last_rx[0] = 12'h018;

    // ss raised after three bits
    cur = 0;
    push_feed(12'h05A);
    wait_fed(feed_wr, "abort_preload");
    r0 = rxv_n[0];
    ss_assert(0);
    xfer(0, 3, 12'h0FF, g0);
    ss_release(0);
    drain("abort");
    chk("abort_rx_valid_cnt", 12'(rxv_n[0] - r0), 12'd0);
    chk("abort_rx_data", rxd_a[0], last_rx[0]);
    chk("abort_miso", 12'(miso_a[0]), 12'd0);
    apply_vec('{0, 12'h096, 12'h03C});

    // Reset in the middle of a word with the TX buffer holding a word
    cur = 0;
    push_feed(12'h077);
    wait_fed(feed_wr, "rst_preload");
    ss_assert(0);
    xfer(0, 4, 12'h0A5, g0);
    push_feed(12'h099);
    wait_fed(feed_wr, "rst_refill");
    chk("pre_rst_tx_ready", 12'(ready_a[0]), 12'd0);
    chk("pre_rst_busy", 12'(busy_a[0]), 12'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_miso", 12'(miso_a[0]), 12'd0);
    chk("midrst_tx_ready", 12'(ready_a[0]), 12'd1);
    chk("midrst_rx_data", rxd_a[0], 12'h000);
    chk("midrst_rx_data_u1", rxd_a[1], 12'h000);
    chk("midrst_rx_valid", 12'(rxv_a[0]), 12'd0);
    chk("midrst_underrun", 12'(ur_a[0]), 12'd0);
    chk("midrst_busy", 12'(busy_a[0]), 12'd0);
    ss[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) last_rx[i] = '0;
    repeat (4) @(negedge clk);
    drain("rst");
    apply_vec('{0, 12'h0C5, 12'h05C});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
